// File: rtl/dma_send_write_queue.sv
// Pending DMA write-to-host request FIFO feeding the packet sender's write port.
// Optional statistics outputs are enabled by defining DMA_SEND_WRITE_QUEUE_STATS_EN.
module dma_send_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned TILE_W = 288
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [TILE_W-1:0]         wr_tile,
    output logic                      wr_full,
    output logic [ADDR_W-1:0]         dma_send_write_queue_data,
    output logic [TILE_W-1:0]         dma_send_write_queue_data2,
    output logic                      dma_send_write_queue_available,
    input  logic                      dma_send_write_queue_re,
`ifdef DMA_SEND_WRITE_QUEUE_STATS_EN
    output logic [$clog2(DEPTH):0]    stat_high_water,
    output logic [15:0]               stat_drops,
`endif
    output logic                      overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + TILE_W;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_data;
    logic [TILE_W-1:0]  r_data2;
    logic               r_available;
    logic               r_full;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_next;

    // Accept decisions use only registered flags, so a pop never frees room for a same-cycle push.
    always_comb begin
        w_push       = wr_en && !r_full;
        w_drop       = wr_en && r_full;
        w_pop        = dma_send_write_queue_re && r_available;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Storage is not reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_addr, wr_tile};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_data2     <= '0;
            r_available <= 1'b0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr           <= r_rd_ptr + 1'b1;
                {r_data, r_data2}  <= r_mem[r_rd_ptr];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count     <= w_count_next;
            r_available <= (w_count_next != '0);
            r_full      <= (w_count_next == CNT_W'(DEPTH));
        end
    end

    assign wr_full                        = r_full;
    assign dma_send_write_queue_data      = r_data;
    assign dma_send_write_queue_data2     = r_data2;
    assign dma_send_write_queue_available = r_available;
    assign overflow                       = r_overflow;

`ifdef DMA_SEND_WRITE_QUEUE_STATS_EN
    logic [CNT_W-1:0] r_high_water;
    logic [15:0]      r_drops;

    // High-water tracks the count register, so it lags a rise in count by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_high_water <= '0;
            r_drops      <= '0;
        end else begin
            if (r_count > r_high_water) begin
                r_high_water <= r_count;
            end
            if (w_drop && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    assign stat_high_water = r_high_water;
    assign stat_drops      = r_drops;
`endif

endmodule
